// File: rtl/uart_tx_frame_if.sv
// Word handshake between the parent core and the UART transmitter.
// The core (master) offers tx_data/tx_valid, and the transmitter (slave) answers with tx_ready.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter fed by a small circular FIFO.
// Queued words go out back-to-back, with each stop bit followed directly by the next start bit.
module uart_tx_frame #(
    parameter int FREQ       = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    uart_tx_frame_if.slave                bus,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, baud_tick, stop_done, fifo_nonempty;

    assign bus.tx_ready  = (fifo_count != (PW+1)'(FIFO_DEPTH));
    assign push          = bus.tx_valid && bus.tx_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign head          = mem[rd_ptr];
    assign baud_tick     = (baud_cnt == BAUD_LAST);
    assign stop_done     = (state == STOP) && baud_tick && (bit_cnt == STOP_LAST);
    // Pop uses the registered count, so a word pushed into an empty FIFO waits one edge.
    assign pop           = fifo_nonempty && ((state == IDLE) || stop_done);

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.tx_data;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= (PARITY == 1) ? ~^head : ^head;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                    if (baud_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                DATA: begin
                    baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                    if (baud_tick) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                            tx      <= (PARITY != 0) ? par_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PAR: begin
                    baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                    if (baud_tick) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                end
                STOP: begin
                    baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                    if (baud_tick) begin
                        if (bit_cnt != STOP_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (pop) begin
                            bit_cnt <= '0;
                            shreg   <= head;
                            par_bit <= (PARITY == 1) ? ~^head : ^head;
                            state   <= START;
                            tx      <= 1'b0;
                        end else begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four differently configured transmitters checked every cycle
// against a frame-level line model, plus hand-computed waveform points.
module tb_uart_tx_frame;
    localparam int NI    = 4;
    localparam int DEPTH = 4;
    localparam int FREQ_A [NI] = '{1600, 300, 500, 1600};
    localparam int DIV_A  [NI] = '{16, 3, 5, 16};
    localparam int DB_A   [NI] = '{8, 8, 8, 5};
    localparam int PAR_A  [NI] = '{0, 2, 1, 0};
    localparam int ST_A   [NI] = '{1, 1, 1, 2};

    logic       clk;
    logic       nrst;
    logic [8:0] data_a  [NI];
    logic       valid_a [NI];
    logic       ready_w [NI];
    logic       tx_w    [NI];
    logic       busy_w  [NI];
    logic [2:0] cnt_w   [NI];

    int errs = 0;
    int chks = 0;

    logic [8:0] mq       [NI][$];
    logic       exp_line [NI][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_frame_if #(.DATA_BITS(DB_A[g])) ifc ();
        assign ifc.tx_data  = data_a[g][DB_A[g]-1:0];
        assign ifc.tx_valid = valid_a[g];
        assign ready_w[g]   = ifc.tx_ready;

        uart_tx_frame #(
            .FREQ(FREQ_A[g]), .BAUD(100), .DATA_BITS(DB_A[g]),
            .PARITY(PAR_A[g]), .STOP_BITS(ST_A[g]), .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .clk       (clk),
            .nrst      (nrst),
            .bus       (ifc),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .fifo_count(cnt_w[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line: one entry per clock cycle of the frame, in transmission order.
    task automatic build_frame(input int i, input logic [8:0] w);
        logic bits [$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int k = 0; k < DB_A[i]; k++) begin
            bits.push_back(w[k]);
            ones += int'(w[k]);
        end
        if (PAR_A[i] == 1) bits.push_back((ones % 2) == 0);
        if (PAR_A[i] == 2) bits.push_back((ones % 2) == 1);
        for (int s = 0; s < ST_A[i]; s++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < DIV_A[i]; c++) exp_line[i].push_back(bits[b]);
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int pre;
            pre = mq[i].size();
            if (nrst) begin
                mq[i].delete();
                exp_line[i].delete();
            end else begin
                if (exp_line[i].size() != 0) void'(exp_line[i].pop_front());
                if (exp_line[i].size() == 0 && pre != 0) build_frame(i, mq[i].pop_front());
                if (valid_a[i] && pre != DEPTH)
                    mq[i].push_back(data_a[i] & 9'((1 << DB_A[i]) - 1));
            end
        end
    endtask

    task automatic tick();
        logic exp_tx;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            exp_tx = (exp_line[i].size() != 0) ? exp_line[i][0] : 1'b1;
            check($sformatf("tx%0d", i),    32'(tx_w[i]),    32'(exp_tx));
            check($sformatf("busy%0d", i),  32'(busy_w[i]),  32'(exp_line[i].size() != 0));
            check($sformatf("count%0d", i), 32'(cnt_w[i]),   32'(mq[i].size()));
            check($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(mq[i].size() != DEPTH));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic [9:0] lit53;
        logic [8:0] words [6];
        lit53 = 10'b1010100110;
        words = '{9'h0A5, 9'h03C, 9'h0F0, 9'h00F, 9'h081, 9'h066};
        nrst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = '0;
        end
        ticks(2);
        check("rst_tx",    32'(tx_w[0]),    32'd1);
        check("rst_busy",  32'(busy_w[0]),  32'd0);
        check("rst_count", 32'(cnt_w[0]),   32'd0);
        check("rst_ready", 32'(ready_w[0]), 32'd1);
        nrst = 1'b0;
        ticks(3);

        // 8N1, 0x53, 16 clocks per bit
        valid_a[0] = 1'b1; data_a[0] = 9'h053;
        tick();
        valid_a[0] = 1'b0;
        check("push53_count", 32'(cnt_w[0]), 32'd1);
        for (int k = 1; k <= 161; k++) begin
            tick();
            if (k <= 160 && (k - 1) % 16 == 0)
                check($sformatf("f53_bit%0d", (k - 1) / 16), 32'(tx_w[0]), 32'(lit53[(k - 1) / 16]));
            if (k == 160) check("f53_busy_last", 32'(busy_w[0]), 32'd1);
            if (k == 161) check("f53_busy_end",  32'(busy_w[0]), 32'd0);
        end

        // 0x6E with even parity (DIV=3) and odd parity (DIV=5)
        valid_a[1] = 1'b1; data_a[1] = 9'h06E;
        valid_a[2] = 1'b1; data_a[2] = 9'h06E;
        tick();
        valid_a[1] = 1'b0; valid_a[2] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 28) check("even_par_bit", 32'(tx_w[1]), 32'd1);
            if (k == 46) check("odd_par_bit",  32'(tx_w[2]), 32'd0);
            if (k == 33) check("even_busy_last", 32'(busy_w[1]), 32'd1);
            if (k == 34) check("even_busy_end",  32'(busy_w[1]), 32'd0);
            if (k == 55) check("odd_busy_last",  32'(busy_w[2]), 32'd1);
            if (k == 56) check("odd_busy_end",   32'(busy_w[2]), 32'd0);
        end

        // 5 data bits, 2 stop bits, upper input bits set
        valid_a[3] = 1'b1; data_a[3] = 9'h1FF;
        tick();
        valid_a[3] = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (k == 1)   check("w5_start", 32'(tx_w[3]), 32'd0);
            if (k == 17)  check("w5_d0",    32'(tx_w[3]), 32'd1);
            if (k == 97)  check("w5_stop1", 32'(tx_w[3]), 32'd1);
            if (k == 113) check("w5_stop2", 32'(tx_w[3]), 32'd1);
            if (k == 128) check("w5_busy_last", 32'(busy_w[3]), 32'd1);
            if (k == 129) check("w5_busy_end",  32'(busy_w[3]), 32'd0);
        end

        // Back-to-back fill, then hold a sixth word across the first pop at full
        for (int j = 0; j < 5; j++) begin
            check($sformatf("fill_ready%0d", j), 32'(ready_w[0]), 32'd1);
            valid_a[0] = 1'b1; data_a[0] = words[j];
            tick();
        end
        check("fill_count", 32'(cnt_w[0]),   32'd4);
        check("fill_full",  32'(ready_w[0]), 32'd0);
        data_a[0] = words[5];
        ticks(156);
        check("full_hold_count", 32'(cnt_w[0]), 32'd4);
        tick();
        check("full_pop_count", 32'(cnt_w[0]),   32'd3);
        check("full_pop_ready", 32'(ready_w[0]), 32'd1);
        tick();
        check("full_refill_count", 32'(cnt_w[0]), 32'd4);
        valid_a[0] = 1'b0;
        tick();
        check("full_once_count", 32'(cnt_w[0]), 32'd4);
        ticks(810);
        check("drain_busy",  32'(busy_w[0]), 32'd0);
        check("drain_count", 32'(cnt_w[0]),  32'd0);

        // Reset during data bit 3 with two words queued
        for (int j = 0; j < 3; j++) begin
            valid_a[0] = 1'b1; data_a[0] = words[j] ^ 9'h0FF;
            tick();
        end
        valid_a[0] = 1'b0;
        check("pre_rst_count", 32'(cnt_w[0]), 32'd2);
        ticks(68);
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        check("mid_rst_tx",    32'(tx_w[0]),    32'd1);
        check("mid_rst_busy",  32'(busy_w[0]),  32'd0);
        check("mid_rst_count", 32'(cnt_w[0]),   32'd0);
        check("mid_rst_ready", 32'(ready_w[0]), 32'd1);
        ticks(200);
        check("post_rst_busy", 32'(busy_w[0]), 32'd0);
        check("post_rst_tx",   32'(tx_w[0]),   32'd1);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with a small input FIFO. A parent core pushes words over a valid/ready handshake, and the block serialises them onto `tx`. Data width, parity mode, stop-bit count, baud divisor and FIFO depth are all generics. It replaces the fixed 8N1, free-running transmit path and sits between the core and the board's serial pin. Words queued in the FIFO are sent back-to-back with no idle gap.

## Interface
Parameters:
- `FREQ`, default 12000000: clock frequency in Hz.
- `BAUD`, default 9600: bit rate. `DIV = FREQ/BAUD` (integer division) gives clocks per bit; it must be at least 2.
- `DATA_BITS`, default 8: payload bits per frame. Legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: number of entries. Must be a power of 2, at least 2.

Ports:
- `clk`, input, 1: the single clock. All logic runs on the rising edge.
- `nrst`, input, 1: synchronous reset, active-high. The block is in reset when `nrst` = 1 at a rising edge.
- `tx_data`, input, DATA_BITS: word to send.
- `tx_valid`, input, 1: `tx_data` is valid this cycle.
- `tx_ready`, output, 1: FIFO can accept a word. Equals `count != FIFO_DEPTH`, combinational from the registered count.
- `tx`, output, 1: serial line, registered, idles at 1.
- `busy`, output, 1: a frame is in progress (state is not IDLE), registered.
- `fifo_count`, output, clog2(FIFO_DEPTH)+1: number of words currently stored.

## Operation
- **Push:** a word is written on any rising edge with `tx_valid` = 1 and `tx_ready` = 1. With `tx_ready` = 0, `tx_valid` is ignored and the data is not stored.
- **State machine:** IDLE, START, DATA, PAR, STOP.
  - IDLE: if `fifo_count` > 0, pop the head word into the shift register and go to START. Otherwise stay in IDLE.
  - START: `tx` = 0 for DIV cycles, then go to DATA.
  - DATA: send DATA_BITS bits, LSB first, DIV cycles each. Then go to PAR if PARITY != 0, else go to STOP.
  - PAR: send the parity bit for DIV cycles, then go to STOP.
    - Odd parity: the bit is chosen so that payload ones plus the parity bit is odd.
    - Even parity: the bit is chosen so that the total is even.
    - Parity is computed from the word latched at pop.
  - STOP: `tx` = 1 for STOP_BITS×DIV cycles. At the last cycle, if the FIFO is non-empty, pop directly into START with no IDLE cycle. Otherwise go to IDLE.
- **Frame length:** exactly DIV×(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- **Baud counter:** width is clog2(DIV). It runs only outside IDLE and is cleared to 0 on every state or bit transition.
- **FIFO:** circular buffer with read and write pointers of clog2(FIFO_DEPTH) bits that wrap modulo depth. `fifo_count` increments on a push only, decrements on a pop only, and is unchanged on a simultaneous push and pop.
  - Full FIFO: a pop and a blocked push in the same cycle leaves the count at DEPTH−1 after the edge. `tx_ready` rises the following cycle.
- **Empty FIFO with push in the same cycle:** the FSM does not pop that cycle; there is no fall-through.
- **Reset:** applies at any time, including mid-frame. The next edge forces:
  - `tx` = 1, `busy` = 0, state = IDLE
  - `fifo_count` = 0, pointers = 0, baud counter = 0
  - `tx_ready` = 1 after reset.
  - The partial frame is abandoned and queued words are discarded.

## Timing
- Push at edge N into an empty FIFO while IDLE:
  - `fifo_count` = 1 after edge N.
  - The pop occurs at edge N+1, so `tx` = 0 and `busy` = 1 from edge N+1.
  - `fifo_count` = 0 after edge N+1.
- Start bit covers edges N+1 .. N+DIV. Data bit k starts at edge N+1+DIV×(1+k).
- Final stop bit ends DIV×frame-bits cycles after the start edge. If the FIFO is empty, `busy` falls on that edge and `tx` stays 1.
- Throughput: one frame per frame length while the FIFO is non-empty; the line is never idle between queued words.
- All outputs except `tx_ready` are registered. `tx_ready` depends only on registered state.

## Test plan
- **8N1, 0x53:** FREQ=1600, BAUD=100 (DIV=16), 8N1. Push 0x53 → `tx` = 0,1,1,0,0,1,0,1,0,1, each held 16 cycles, starting 1 cycle after the push. `busy` is high for 160 cycles.
- **Even parity:** PARITY=2, push 0x6E (five ones) → parity bit = 1. PARITY=1 with 0x6E → parity bit = 0. Frame is 11 bits.
- **Back-to-back fill:** FIFO_DEPTH=4, push 5 words on consecutive cycles.
  - The 1st is popped at once and the next 4 fill the FIFO.
  - `tx_ready` is never low at a push edge, because the first pop frees a slot.
  - The 6th push waits with `tx_ready` = 0.
  - All frames are contiguous with no extra stop-level cycles.
- **Width and stop bits:** DATA_BITS=5, STOP_BITS=2, push 0x1F → start 0, five 1s, stop high for 32 cycles. Upper input bits are ignored.
- **Reset mid-frame:** assert `nrst` during data bit 3 with 2 words queued → after the next edge `tx` = 1, `busy` = 0, `fifo_count` = 0. No further frame is sent until a new push.
- **Full boundary:** FIFO full, hold `tx_valid` = 1 across a pop → the count goes DEPTH → DEPTH−1 → DEPTH. The word is accepted exactly once, and the data order is preserved.
